// File: rtl/my_vector_mac.sv
// my_vector_mac: pipelined multi-lane multiply-accumulate engine.
//
// Each accepted beat carries LANES operand pairs. The pairs are multiplied in S1
// and summed by an adder tree in S2. In S3 they are accumulated across beats until
// a beat marked last, and the finished dot product is held on a valid/ready port.
//
// Ports:
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset
//   ain, bin   packed operands, lane i at [i*BITWIDTH +: BITWIDTH]
//   sgn        1 = two's-complement operands for this beat, 0 = unsigned
//   in_last    final beat of the current dot product
//   in_valid   beat present
//   in_ready   beat can be accepted this cycle
//   dout       completed dot product (OUT_W bits, wraps modulo 2^OUT_W)
//   out_valid  dout holds an unconsumed result
//   out_ready  consumer takes dout this cycle
//
// The whole pipeline shares one advance enable. While a result is held and not
// being taken, every stage freezes and in_ready drops.

module my_vector_mac #(
   parameter int unsigned BITWIDTH   = 32,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ACC_GUARD  = 8,
   localparam int unsigned OUT_W     = 2 * BITWIDTH + $clog2(LANES) + ACC_GUARD
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [LANES*BITWIDTH-1:0] ain,
   input  logic [LANES*BITWIDTH-1:0] bin,
   input  logic                      sgn,
   input  logic                      in_last,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [OUT_W-1:0]          dout,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int unsigned PW = 2 * BITWIDTH;

   // Operand widened to product width. The low PW bits of the product of two
   // widened operands are the exact product for both signed and unsigned inputs.
   function automatic logic [PW-1:0] ext_op(input logic [BITWIDTH-1:0] v, input logic s);
      return {{BITWIDTH{s & v[BITWIDTH-1]}}, v};
   endfunction

   // Product widened to accumulator width according to the sgn of its beat.
   function automatic logic [OUT_W-1:0] ext_prod(input logic [PW-1:0] p, input logic s);
      return {{(OUT_W - PW){s & p[PW-1]}}, p};
   endfunction

   logic adv;

   // S1 state
   logic [LANES-1:0][PW-1:0] prod_d;
   logic [LANES-1:0][PW-1:0] prod_q;
   logic                     s1_valid_q;
   logic                     s1_last_q;
   logic                     s1_sgn_q;

   // S2 state
   logic [OUT_W-1:0]         tree [2*LANES-1];
   logic [OUT_W-1:0]         sum_d;
   logic [OUT_W-1:0]         sum_q;
   logic                     s2_valid_q;
   logic                     s2_last_q;

   // S3 state
   logic [OUT_W-1:0]         acc_d;
   logic [OUT_W-1:0]         acc_q;
   logic [OUT_W-1:0]         dout_d;
   logic [OUT_W-1:0]         dout_q;
   logic                     out_valid_d;
   logic                     out_valid_q;

   // Stall only when a held result is not being taken.
   assign adv       = !(out_valid_q && !out_ready);
   assign in_ready  = adv;
   assign dout      = dout_q;
   assign out_valid = out_valid_q;

   // S1: per-lane products.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         prod_d[i] = ext_op(ain[i*BITWIDTH +: BITWIDTH], sgn) *
                     ext_op(bin[i*BITWIDTH +: BITWIDTH], sgn);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sgn_q   <= 1'b0;
         prod_q     <= '0;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         // Payload only loads on a real beat; bubbles keep the old data.
         if (in_valid) begin
            prod_q    <= prod_d;
            s1_last_q <= in_last;
            s1_sgn_q  <= sgn;
         end
      end
   end

   // S2: binary adder tree in heap layout. Leaves sit at LANES-1 .. 2*LANES-2,
   // and node n sums children 2n+1 and 2n+2. The root is node 0.
   always_comb begin
      tree = '{default: '0};
      for (int i = 0; i < int'(LANES); i++) begin
         tree[int'(LANES) - 1 + i] = ext_prod(prod_q[i], s1_sgn_q);
      end
      for (int n = int'(LANES) - 2; n >= 0; n--) begin
         tree[n] = tree[2*n+1] + tree[2*n+2];
      end
      sum_d = tree[0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         sum_q      <= '0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q     <= sum_d;
            s2_last_q <= s1_last_q;
         end
      end
   end

   // S3: accumulate, and on last publish and clear in the same edge. These values
   // only load when adv is high. adv high means any held result is being drained,
   // so out_valid falls unless a new result lands.
   always_comb begin
      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
         if (s2_last_q) begin
            dout_d      = acc_q + sum_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
         end else begin
            acc_d = acc_q + sum_q;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_my_vector_mac.sv
// Directed bench for my_vector_mac with BITWIDTH=8, LANES=4, ACC_GUARD=8 (OUT_W=26).
// Inputs are driven and outputs sampled on the falling edge.

module tb_my_vector_mac;

   localparam int unsigned BW = 8;
   localparam int unsigned LN = 4;
   localparam int unsigned AG = 8;
   localparam int unsigned OW = 2 * BW + $clog2(LN) + AG;

   logic             clk       = 1'b0;
   logic             resetn    = 1'b0;
   logic [LN*BW-1:0] ain       = '0;
   logic [LN*BW-1:0] bin       = '0;
   logic             sgn       = 1'b0;
   logic             in_last   = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [OW-1:0]    dout;
   logic             out_valid;
   logic             out_ready = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int got;

   typedef struct {
      string        name;
      logic [31:0]  a;
      logic [31:0]  b;
      logic         s;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t vecs[6];
   logic [OW-1:0] bp_exp[3];

   my_vector_mac #(
      .BITWIDTH (BW),
      .LANES    (LN),
      .ACC_GUARD(AG)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .ain      (ain),
      .bin      (bin),
      .sgn      (sgn),
      .in_last  (in_last),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .dout     (dout),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got still running, required finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a beat at a falling edge and hold it until it is accepted.
   // Returns at the falling edge after the accepting rising edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic l);
      bit took;
      took     = 1'b0;
      ain      = a;
      bin      = b;
      sgn      = s;
      in_last  = l;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !took; i++) begin
         #1;
         took = in_ready;
         @(posedge clk);
         @(negedge clk);
      end
      if (!took) begin
         n_vec++;
         n_err++;
         $display("FAIL send_accept: got in_ready stuck low, required beat accepted");
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // n beats of all-lanes 0xFF*0xFF, the last one marked last.
   task automatic run_wrap(input int n);
      longint unsigned tot;
      logic [63:0]     tv;
      for (int i = 0; i < n; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, i == n - 1);
      idle();
      tot = longint'(n) * 64'd260100;
      tv  = tot;
      tick();
      tick();
      check($sformatf("wrap%0d valid", n), out_valid, 1);
      check($sformatf("wrap%0d dout", n), dout, tv[OW-1:0]);
      tick();
   endtask

   initial begin
      vecs[0] = '{"u_70",    32'h0403_0201, 32'h0807_0605, 1'b0, 26'd70};
      vecs[1] = '{"s_m258",  32'h0000_80FF, 32'h0000_0202, 1'b1, 26'h3FF_FEFE};
      vecs[2] = '{"u_766",   32'h0000_80FF, 32'h0000_0202, 1'b0, 26'd766};
      vecs[3] = '{"s_mix",   32'h0180_807F, 32'hFF7F_807F, 1'b1, 26'd16256};
      vecs[4] = '{"u_allff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 26'd260100};
      vecs[5] = '{"zero",    32'h0000_0000, 32'h1234_5678, 1'b1, 26'd0};
      bp_exp  = '{26'd70, 26'd12, 26'd11};

      // Reset state.
      @(negedge clk);
      check("rst out_valid", out_valid, 0);
      check("rst dout", dout, 0);
      check("rst in_ready", in_ready, 1);
      resetn = 1'b1;
      tick();

      // Single-beat dot products: result visible after the second edge past accept.
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1);
         idle();
         check({vecs[i].name, " valid@k"}, out_valid, 0);
         tick();
         check({vecs[i].name, " valid@k+1"}, out_valid, 0);
         tick();
         check({vecs[i].name, " valid@k+2"}, out_valid, 1);
         check({vecs[i].name, " dout"}, dout, vecs[i].exp);
         tick();
         check({vecs[i].name, " drained"}, out_valid, 0);
      end

      // Three-beat sum followed directly by a new one-beat vector.
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b1);
      send(32'h0000_0001, 32'h0000_0009, 1'b0, 1'b1);
      idle();
      check("b2b valid early", out_valid, 0);
      tick();
      check("b2b valid 24", out_valid, 1);
      check("b2b dout 24", dout, 24);
      tick();
      check("b2b valid 9", out_valid, 1);
      check("b2b dout 9", dout, 9);
      tick();
      check("b2b drained", out_valid, 0);

      // A gap in in_valid between beats of one dot product has no effect.
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
      idle();
      tick();
      tick();
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b1);
      idle();
      tick();
      tick();
      check("gap valid", out_valid, 1);
      check("gap dout", dout, 16);
      tick();

      // Backpressure: results 70, 12, 11 pile up behind a stalled consumer.
      out_ready = 1'b0;
      fork
         begin
            send(32'h0403_0201, 32'h0807_0605, 1'b0, 1'b1);
            send(32'h0101_0101, 32'h0303_0303, 1'b0, 1'b1);
            send(32'h0000_0002, 32'h0000_0005, 1'b0, 1'b0);
            send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
            idle();
         end
         begin
            for (int i = 0; i < 20 && !out_valid; i++) tick();
            check("bp first valid", out_valid, 1);
            for (int i = 0; i < 4; i++) begin
               tick();
               check("bp stall in_ready", in_ready, 0);
               check("bp stall valid", out_valid, 1);
               check("bp stall dout", dout, 70);
            end
            check("bp res0", dout, bp_exp[0]);
            got       = 1;
            out_ready = 1'b1;
            for (int i = 0; i < 20 && got < 3; i++) begin
               tick();
               if (out_valid) begin
                  check($sformatf("bp res%0d", got), dout, bp_exp[got]);
                  got++;
               end
            end
            check("bp result count", got, 3);
            for (int i = 0; i < 3; i++) begin
               tick();
               check("bp no duplicate", out_valid, 0);
            end
         end
      join

      // Accumulator guard range, then a run long enough to wrap modulo 2^OW.
      run_wrap((1 << AG) + 2);
      run_wrap(600);

      // Reset with partial sums in flight: no residue afterwards.
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
      send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
      idle();
      resetn = 1'b0;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst dout", dout, 0);
      check("midrst in_ready", in_ready, 1);
      tick();
      check("midrst hold dout", dout, 0);
      resetn = 1'b1;
      tick();
      send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1);
      idle();
      tick();
      tick();
      check("postrst valid", out_valid, 1);
      check("postrst dout", dout, 9);
      tick();
      check("postrst drained", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
